// File: rtl/mgmt_bus_router.sv
// -----------------------------------------------------------------------------
// mgmt_bus_router
//
// Address-decoding router between the QSPI management bridge read/write bus
// and NUM_PORTS register-block ports, all on the single management clock.
// The upper address bits (addr[ADDR_WIDTH-1:PORT_ADDR_BITS]) select the port.
// The low PORT_ADDR_BITS bits are forwarded on a shared address bus.
//
// Writes are registered with one cycle of latency and are independent of
// reads. Reads are tracked one at a time by an IDLE/WAIT FSM. A read to an
// unmapped port index returns ERR_DATA in the next cycle. A read that arrives
// while another read is outstanding is dropped and sets the sticky
// err_overlap flag.
//
// Optional feature macro: MGMT_BUS_ROUTER_TIMEOUT_EN
//   defined     - a read still waiting after TIMEOUT_CYCLES cycles completes
//                 with ERR_DATA, and timeout_count is incremented (saturating).
//   not defined - a read waits until the selected port responds, and only rst
//                 frees a hung read. timeout_count is tied to 0.
//
// Ports
//   clk, rst              management clock, synchronous active-high reset
//   rd_en/rd_addr         host read strobe and address
//   rd_valid/rd_data      read completion pulse and data (rd_data is held)
//   wr_en/wr_addr/wr_data host write strobe, address and data
//   port_rd_en/_addr      one-hot read strobe, shared read address
//   port_rd_valid/_data   per-port response strobe and packed data
//   port_wr_en/_addr/_data one-hot write strobe, shared address and data
//   busy                  a read is outstanding
//   err_overlap           sticky: rd_en was seen while busy
//   timeout_count         saturating count of timed-out reads
// -----------------------------------------------------------------------------
module mgmt_bus_router #(
  parameter int                    NUM_PORTS      = 8,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    PORT_ADDR_BITS = 12,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(8'hFF)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic [NUM_PORTS-1:0]            port_rd_en,
  output logic [PORT_ADDR_BITS-1:0]       port_rd_addr,
  input  logic [NUM_PORTS-1:0]            port_rd_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_rd_data,
  output logic [NUM_PORTS-1:0]            port_wr_en,
  output logic [PORT_ADDR_BITS-1:0]       port_wr_addr,
  output logic [DATA_WIDTH-1:0]           port_wr_data,
  output logic                            busy,
  output logic                            err_overlap,
  output logic [15:0]                     timeout_count
);

  localparam int IDX_W = ADDR_WIDTH - PORT_ADDR_BITS;
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]     w_rd_idx;
  logic [IDX_W-1:0]     w_wr_idx;
  logic                 w_rd_hit;
  logic                 w_wr_hit;
  logic [SEL_W-1:0]     w_rd_sel;
  logic [SEL_W-1:0]     w_wr_sel;
  logic [NUM_PORTS-1:0] w_rd_onehot;
  logic [NUM_PORTS-1:0] w_wr_onehot;

  assign w_rd_idx    = rd_addr[ADDR_WIDTH-1:PORT_ADDR_BITS];
  assign w_wr_idx    = wr_addr[ADDR_WIDTH-1:PORT_ADDR_BITS];
  assign w_rd_hit    = (32'(w_rd_idx) < NUM_PORTS);
  assign w_wr_hit    = (32'(w_wr_idx) < NUM_PORTS);
  assign w_rd_sel    = w_rd_idx[SEL_W-1:0];
  assign w_wr_sel    = w_wr_idx[SEL_W-1:0];
  assign w_rd_onehot = NUM_PORTS'(1) << w_rd_sel;
  assign w_wr_onehot = NUM_PORTS'(1) << w_wr_sel;

  // Unpack the per-port response data so the latched selector can index it.
  logic [DATA_WIDTH-1:0] w_port_data [NUM_PORTS];
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign w_port_data[gi] = port_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Write path: one registered stage, no interaction with reads
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]      r_port_wr_en;
  logic [PORT_ADDR_BITS-1:0] r_port_wr_addr;
  logic [DATA_WIDTH-1:0]     r_port_wr_data;

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port_wr_en   <= '0;
      r_port_wr_addr <= '0;
      r_port_wr_data <= '0;
    end else begin
      r_port_wr_en <= (wr_en && w_wr_hit) ? w_wr_onehot : '0;
      if (wr_en && w_wr_hit) begin
        r_port_wr_addr <= wr_addr[PORT_ADDR_BITS-1:0];
        r_port_wr_data <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  state_t                    r_state;
  state_t                    w_next_state;
  logic [SEL_W-1:0]          r_sel;
  logic [NUM_PORTS-1:0]      r_port_rd_en;
  logic [PORT_ADDR_BITS-1:0] r_port_rd_addr;
  logic                      r_rd_valid;
  logic [DATA_WIDTH-1:0]     r_rd_data;
  logic                      r_err_overlap;

  logic w_rd_issue;   // mapped read accepted in IDLE
  logic w_rd_unmap;   // unmapped read accepted in IDLE
  logic w_rd_done;    // selected port responded while waiting
  logic w_rd_tmo;     // wait budget exhausted with no response
  logic w_overlap;    // read request arrived while busy

`ifdef MGMT_BUS_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_wait_cnt;
  logic [15:0]      r_timeout_count;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_rd_issue   = 1'b0;
    w_rd_unmap   = 1'b0;
    w_rd_done    = 1'b0;
    w_rd_tmo     = 1'b0;
    w_overlap    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_en) begin
          if (w_rd_hit) begin
            w_rd_issue   = 1'b1;
            w_next_state = ST_WAIT;
          end else begin
            w_rd_unmap = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_overlap = rd_en;
        // The selected port is sampled from the strobe cycle onward, so a
        // combinational responder completes in the very next cycle. A
        // response always beats a timeout that would fire in the same cycle.
        if (port_rd_valid[r_sel]) begin
          w_rd_done    = 1'b1;
          w_next_state = ST_IDLE;
        end
`ifdef MGMT_BUS_ROUTER_TIMEOUT_EN
        else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_rd_tmo     = 1'b1;
          w_next_state = ST_IDLE;
        end
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_sel          <= '0;
      r_port_rd_en   <= '0;
      r_port_rd_addr <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
      r_err_overlap  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_port_rd_en <= w_rd_issue ? w_rd_onehot : '0;
      r_rd_valid   <= w_rd_unmap | w_rd_done | w_rd_tmo;
      if (w_rd_issue) begin
        r_sel          <= w_rd_sel;
        r_port_rd_addr <= rd_addr[PORT_ADDR_BITS-1:0];
      end
      if (w_rd_done) begin
        r_rd_data <= w_port_data[r_sel];
      end else if (w_rd_unmap || w_rd_tmo) begin
        r_rd_data <= ERR_DATA;
      end
      if (w_overlap) begin
        r_err_overlap <= 1'b1;
      end
    end
  end

`ifdef MGMT_BUS_ROUTER_TIMEOUT_EN
  // Wait counter restarts on every issued read and counts silent WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt      <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_rd_issue) begin
        r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_rd_tmo && (r_timeout_count != 16'hFFFF)) begin
        r_timeout_count <= r_timeout_count + 16'd1;
      end
    end
  end

  assign timeout_count = r_timeout_count;
`else
  assign timeout_count = 16'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign port_rd_en   = r_port_rd_en;
  assign port_rd_addr = r_port_rd_addr;
  assign port_wr_en   = r_port_wr_en;
  assign port_wr_addr = r_port_wr_addr;
  assign port_wr_data = r_port_wr_data;
  assign busy         = (r_state == ST_WAIT);
  assign err_overlap  = r_err_overlap;

endmodule

// File: tb/tb_mgmt_bus_router.sv
// -----------------------------------------------------------------------------
// tb_mgmt_bus_router
//
// Self-checking bench for mgmt_bus_router with default parameters.
// Inputs are driven 1 time unit after the rising edge. Registered outputs are
// read at that same point, well away from the next edge. "Cycle k" is the
// interval after the k-th rising edge: inputs set in cycle k are seen at the
// outputs in cycle k+1.
// -----------------------------------------------------------------------------
module tb_mgmt_bus_router;

  localparam int NP   = 8;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int PAB  = 12;
  localparam int TMO  = 64;
  localparam logic [7:0] ERR = 8'hFF;

  logic               clk;
  logic               rst;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [NP-1:0]      port_rd_en;
  logic [PAB-1:0]     port_rd_addr;
  logic [NP-1:0]      port_rd_valid;
  logic [NP*DW-1:0]   port_rd_data;
  logic [NP-1:0]      port_wr_en;
  logic [PAB-1:0]     port_wr_addr;
  logic [DW-1:0]      port_wr_data;
  logic               busy;
  logic               err_overlap;
  logic [15:0]        timeout_count;

  mgmt_bus_router #(
    .NUM_PORTS      (NP),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .PORT_ADDR_BITS (PAB),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (ERR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .port_rd_en    (port_rd_en),
    .port_rd_addr  (port_rd_addr),
    .port_rd_valid (port_rd_valid),
    .port_rd_data  (port_rd_data),
    .port_wr_en    (port_wr_en),
    .port_wr_addr  (port_wr_addr),
    .port_wr_data  (port_wr_data),
    .busy          (busy),
    .err_overlap   (err_overlap),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en         = 1'b0;
    rd_addr       = '0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    port_rd_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-cycle vectors applied from IDLE.
  typedef struct {
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  e_pwe;
    logic [11:0] e_pwa;
    logic [7:0]  e_pwd;
    logic        e_rv;
    logic [7:0]  e_rd;
    logic [7:0]  e_pre;
  } vec_t;

  vec_t vecs [6];

  // Hang guard: the bench is cycle-bounded, so this fires only on a stall.
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    bit still_busy;

    rst          = 1'b0;
    port_rd_data = '0;
    idle_inputs();

    vecs[0] = '{1'b1, 16'h3012, 8'hA5, 1'b0, 16'h0000, 8'h08, 12'h012, 8'hA5, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 16'h7FFF, 8'h3C, 1'b0, 16'h0000, 8'h80, 12'hFFF, 8'h3C, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b1, 16'h0000, 8'h01, 1'b0, 16'h0000, 8'h01, 12'h000, 8'h01, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 16'h8123, 8'h77, 1'b0, 16'h0000, 8'h00, 12'h000, 8'h01, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hF000, 8'h00, 12'h000, 8'h01, 1'b1, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 16'h5055, 8'h42, 1'b1, 16'h9ABC, 8'h20, 12'h055, 8'h42, 1'b1, 8'hFF, 8'h00};

    // ---------------- reset state ----------------
    do_reset();
    check("reset_rd_valid",      32'(rd_valid),      32'h0);
    check("reset_rd_data",       32'(rd_data),       32'h0);
    check("reset_port_rd_en",    32'(port_rd_en),    32'h0);
    check("reset_port_rd_addr",  32'(port_rd_addr),  32'h0);
    check("reset_port_wr_en",    32'(port_wr_en),    32'h0);
    check("reset_port_wr_addr",  32'(port_wr_addr),  32'h0);
    check("reset_port_wr_data",  32'(port_wr_data),  32'h0);
    check("reset_busy",          32'(busy),          32'h0);
    check("reset_err_overlap",   32'(err_overlap),   32'h0);
    check("reset_timeout_count", 32'(timeout_count), 32'h0);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 6; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      rd_en   = vecs[i].rd_en;
      rd_addr = vecs[i].rd_addr;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_port_wr_en", i),   32'(port_wr_en),   32'(vecs[i].e_pwe));
      check($sformatf("vec%0d_port_wr_addr", i), 32'(port_wr_addr), 32'(vecs[i].e_pwa));
      check($sformatf("vec%0d_port_wr_data", i), 32'(port_wr_data), 32'(vecs[i].e_pwd));
      check($sformatf("vec%0d_rd_valid", i),     32'(rd_valid),     32'(vecs[i].e_rv));
      check($sformatf("vec%0d_rd_data", i),      32'(rd_data),      32'(vecs[i].e_rd));
      check($sformatf("vec%0d_port_rd_en", i),   32'(port_rd_en),   32'(vecs[i].e_pre));
      check($sformatf("vec%0d_busy", i),         32'(busy),         32'h0);
      tick();
      check($sformatf("vec%0d_wr_strobe_drop", i), 32'(port_wr_en), 32'h0);
      check($sformatf("vec%0d_rd_valid_drop", i),  32'(rd_valid),   32'h0);
    end

    // ---------------- read port 2, answer in cycle 5 ----------------
    rd_en   = 1'b1;
    rd_addr = 16'h2040;
    tick();                                   // cycle 1
    rd_en = 1'b0;
    check("seqB_port_rd_en",   32'(port_rd_en),   32'h04);
    check("seqB_port_rd_addr", 32'(port_rd_addr), 32'h040);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("seqB_busy_c%0d", c),     32'(busy),     32'h1);
      check($sformatf("seqB_rd_valid_c%0d", c), 32'(rd_valid), 32'h0);
      if (c == 2) check("seqB_strobe_one_cycle", 32'(port_rd_en), 32'h0);
      port_rd_valid = '0;
      if (c == 3) begin
        port_rd_valid        = 8'h08;         // wrong port, must be ignored
        port_rd_data[3*8 +: 8] = 8'hEE;
      end
      if (c == 5) begin
        port_rd_valid          = 8'h04;
        port_rd_data[2*8 +: 8] = 8'h5C;
      end
      tick();
    end
    port_rd_valid = '0;                       // cycle 6
    check("seqB_rd_valid_c6", 32'(rd_valid), 32'h1);
    check("seqB_rd_data_c6",  32'(rd_data),  32'h5C);
    check("seqB_busy_c6",     32'(busy),     32'h0);
    tick();                                   // cycle 7
    check("seqB_rd_valid_c7", 32'(rd_valid), 32'h0);
    check("seqB_rd_data_hold", 32'(rd_data), 32'h5C);

    // ---------------- overlap: read port 4, second rd_en in cycle 3 ----------------
    rd_en   = 1'b1;
    rd_addr = 16'h4000;
    tick();                                   // cycle 1
    rd_en = 1'b0;
    check("seqC_port_rd_en", 32'(port_rd_en), 32'h10);
    tick();                                   // cycle 2
    port_rd_valid          = 8'h01;           // port 0, not selected
    port_rd_data[0*8 +: 8] = 8'h99;
    tick();                                   // cycle 3
    port_rd_valid = '0;
    check("seqC_rd_valid_c3", 32'(rd_valid), 32'h0);
    check("seqC_busy_c3",     32'(busy),     32'h1);
    check("seqC_overlap_c3",  32'(err_overlap), 32'h0);
    rd_en   = 1'b1;
    rd_addr = 16'h1000;
    tick();                                   // cycle 4
    rd_en = 1'b0;
    check("seqC_overlap_c4",    32'(err_overlap), 32'h1);
    check("seqC_port_rd_en_c4", 32'(port_rd_en),  32'h0);
    check("seqC_busy_c4",       32'(busy),        32'h1);
    port_rd_valid          = 8'h10;
    port_rd_data[4*8 +: 8] = 8'h3E;
    tick();                                   // cycle 5
    port_rd_valid = '0;
    check("seqC_rd_valid_c5", 32'(rd_valid), 32'h1);
    check("seqC_rd_data_c5",  32'(rd_data),  32'h3E);

    // ---------------- combinational responder, back-to-back read ----------------
    tick();
    rd_en   = 1'b1;
    rd_addr = 16'h6000;
    tick();                                   // cycle 1
    rd_en = 1'b0;
    check("seqD_port_rd_en", 32'(port_rd_en), 32'h40);
    port_rd_valid          = 8'h40;           // respond in the strobe cycle
    port_rd_data[6*8 +: 8] = 8'hD4;
    tick();                                   // cycle 2
    port_rd_valid = '0;
    check("seqD_rd_valid_c2", 32'(rd_valid), 32'h1);
    check("seqD_rd_data_c2",  32'(rd_data),  32'hD4);
    rd_en   = 1'b1;                           // accepted alongside rd_valid
    rd_addr = 16'h7123;
    tick();                                   // cycle 3
    rd_en = 1'b0;
    check("seqD_port_rd_en_c3",   32'(port_rd_en),   32'h80);
    check("seqD_port_rd_addr_c3", 32'(port_rd_addr), 32'h123);
    check("seqD_busy_c3",         32'(busy),         32'h1);
    check("seqD_overlap_sticky",  32'(err_overlap),  32'h1);
    port_rd_valid          = 8'h80;
    port_rd_data[7*8 +: 8] = 8'h11;
    tick();                                   // cycle 4
    port_rd_valid = '0;
    check("seqD_rd_valid_c4", 32'(rd_valid), 32'h1);
    check("seqD_rd_data_c4",  32'(rd_data),  32'h11);

    // ---------------- reset during a read ----------------
    tick();
    rd_en   = 1'b1;
    rd_addr = 16'h5000;
    tick();                                   // cycle 1
    rd_en = 1'b0;
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    rst = 1'b1;
    tick();                                   // cycle 4
    rst = 1'b0;
    check("seqE_busy_c4",     32'(busy),        32'h0);
    check("seqE_rd_valid_c4", 32'(rd_valid),    32'h0);
    check("seqE_overlap_clr", 32'(err_overlap), 32'h0);
    saw_valid              = 1'b0;
    port_rd_valid          = 8'h20;           // late response while IDLE
    port_rd_data[5*8 +: 8] = 8'h77;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rd_valid) saw_valid = 1'b1;
    end
    port_rd_valid = '0;
    check("seqE_no_rd_valid", 32'(saw_valid), 32'h0);
    rd_en   = 1'b1;
    rd_addr = 16'h5000;
    tick();
    rd_en = 1'b0;
    check("seqE_fresh_port_rd_en", 32'(port_rd_en), 32'h20);
    port_rd_valid          = 8'h20;
    port_rd_data[5*8 +: 8] = 8'h5A;
    tick();
    port_rd_valid = '0;
    check("seqE_fresh_rd_valid", 32'(rd_valid), 32'h1);
    check("seqE_fresh_rd_data",  32'(rd_data),  32'h5A);

    // ---------------- silent port ----------------
    tick();
`ifdef MGMT_BUS_ROUTER_TIMEOUT_EN
    rd_en   = 1'b1;
    rd_addr = 16'h1000;
    tick();                                   // cycle 1
    rd_en     = 1'b0;
    saw_valid = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      if (rd_valid) saw_valid = 1'b1;
      tick();
    end                                       // cycle TMO+1
    check("seqF_no_early_valid", 32'(saw_valid),     32'h0);
    check("seqF_tmo_rd_valid",   32'(rd_valid),      32'h1);
    check("seqF_tmo_rd_data",    32'(rd_data),       32'(ERR));
    check("seqF_tmo_count",      32'(timeout_count), 32'h1);
    check("seqF_tmo_busy",       32'(busy),          32'h0);
    tick();
    rd_en   = 1'b1;
    rd_addr = 16'h1000;
    tick();                                   // cycle 1
    rd_en = 1'b0;
    for (int c = 1; c < TMO; c++) tick();     // cycle TMO
    port_rd_valid          = 8'h02;           // response ties with timeout
    port_rd_data[1*8 +: 8] = 8'h6B;
    tick();                                   // cycle TMO+1
    port_rd_valid = '0;
    check("seqF_race_rd_valid", 32'(rd_valid),      32'h1);
    check("seqF_race_rd_data",  32'(rd_data),       32'h6B);
    check("seqF_race_count",    32'(timeout_count), 32'h1);
`else
    rd_en   = 1'b1;
    rd_addr = 16'h1000;
    tick();
    rd_en      = 1'b0;
    saw_valid  = 1'b0;
    still_busy = 1'b1;
    for (int c = 0; c < 3 * TMO; c++) begin
      if (rd_valid) saw_valid = 1'b1;
      if (!busy) still_busy = 1'b0;
      tick();
    end
    check("seqF_hang_no_valid", 32'(saw_valid),     32'h0);
    check("seqF_hang_busy",     32'(still_busy),    32'h1);
    check("seqF_hang_count",    32'(timeout_count), 32'h0);
    port_rd_valid          = 8'h02;
    port_rd_data[1*8 +: 8] = 8'h6B;
    tick();
    port_rd_valid = '0;
    check("seqF_late_rd_valid", 32'(rd_valid), 32'h1);
    check("seqF_late_rd_data",  32'(rd_data),  32'h6B);
`endif

    // ---------------- randomized run against a transaction model ----------------
    do_reset();
    begin
      bit          m_busy;
      int          m_sel;
      int          m_start;
      bit          m_ovl;
      int          m_tmo;
      logic [7:0]  m_rd_data;
      logic [11:0] m_prd_addr;
      logic [11:0] m_pwa;
      logic [7:0]  m_pwd;
      logic [7:0]  e_pwe;
      logic [7:0]  e_pre;
      bit          e_rv;
      int          ridx;
      int          widx;
      bit          quiet;

      m_busy     = 1'b0;
      m_sel      = 0;
      m_start    = 0;
      m_ovl      = 1'b0;
      m_tmo      = 0;
      m_rd_data  = '0;
      m_prd_addr = '0;
      m_pwa      = '0;
      m_pwd      = '0;

      for (int t = 0; t < 900; t++) begin
        quiet         = ((t / 150) % 2) == 1;
        rd_en         = ($urandom_range(3) == 0);
        rd_addr       = 16'($urandom);
        wr_en         = ($urandom_range(2) == 0);
        wr_addr       = 16'($urandom);
        wr_data       = 8'($urandom);
        port_rd_data  = {$urandom, $urandom};
        port_rd_valid = quiet ? '0 : (8'($urandom) & 8'($urandom));

        // Writes: accepted iff the index names an existing port.
        widx  = int'(wr_addr[15:12]);
        e_pwe = '0;
        if (wr_en && widx < NP) begin
          e_pwe = 8'(1 << widx);
          m_pwa = wr_addr[11:0];
          m_pwd = wr_data;
        end

        // Reads: one outstanding transaction, tracked by its start cycle.
        ridx  = int'(rd_addr[15:12]);
        e_pre = '0;
        e_rv  = 1'b0;
        if (!m_busy) begin
          if (rd_en) begin
            if (ridx < NP) begin
              e_pre      = 8'(1 << ridx);
              m_prd_addr = rd_addr[11:0];
              m_sel      = ridx;
              m_start    = t;
              m_busy     = 1'b1;
            end else begin
              e_rv      = 1'b1;
              m_rd_data = ERR;
            end
          end
        end else begin
          if (rd_en) m_ovl = 1'b1;
          if (port_rd_valid[m_sel]) begin
            e_rv      = 1'b1;
            m_rd_data = port_rd_data[m_sel*8 +: 8];
            m_busy    = 1'b0;
          end
`ifdef MGMT_BUS_ROUTER_TIMEOUT_EN
          else if (t - m_start == TMO) begin
            e_rv      = 1'b1;
            m_rd_data = ERR;
            if (m_tmo < 65535) m_tmo++;
            m_busy    = 1'b0;
          end
`endif
        end

        tick();
        check("rnd_rd_valid",      32'(rd_valid),      32'(e_rv));
        check("rnd_rd_data",       32'(rd_data),       32'(m_rd_data));
        check("rnd_port_rd_en",    32'(port_rd_en),    32'(e_pre));
        check("rnd_port_rd_addr",  32'(port_rd_addr),  32'(m_prd_addr));
        check("rnd_port_wr_en",    32'(port_wr_en),    32'(e_pwe));
        check("rnd_port_wr_addr",  32'(port_wr_addr),  32'(m_pwa));
        check("rnd_port_wr_data",  32'(port_wr_data),  32'(m_pwd));
        check("rnd_busy",          32'(busy),          32'(m_busy));
        check("rnd_err_overlap",   32'(err_overlap),   32'(m_ovl));
        check("rnd_timeout_count", 32'(timeout_count), 32'(m_tmo));
      end
    end

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
